// File: rtl/sim_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sim_ctrl_pkg
// Shared encodings for the simulation run/finish controller.
//   run_state_t  : controller state; the value is also the externally
//                  visible status code, so the encoding is fixed.
//   TOHOST_PASS  : value stored to tohost that means "test passed".
//   is_terminal(): true for the sticky end-of-test states.
// ---------------------------------------------------------------------------
package sim_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_HOLD    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_HANG    = 3'd4,
        ST_TIMEOUT = 3'd5
    } run_state_t;

    localparam int unsigned TOHOST_PASS = 1;

    // Every state other than HOLD and RUN ends the test and stays put
    // until restart or harness reset.
    function automatic logic is_terminal(input run_state_t s);
        return (s == ST_PASS) || (s == ST_FAIL) ||
               (s == ST_HANG) || (s == ST_TIMEOUT);
    endfunction

endpackage

// File: rtl/sim_sat_counter.sv
// ---------------------------------------------------------------------------
// sim_sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset, clears q
//   clr   : synchronous clear, wins over inc
//   inc   : count enable
//   q     : current count
// ---------------------------------------------------------------------------
module sim_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    // A long soak run must never wrap back to a small, misleading count,
    // so the counter freezes once every bit is set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/sim_run_controller.sv
// ---------------------------------------------------------------------------
// sim_run_controller
// Run/finish controller that sits beside an RV32I core in a bench or on an
// FPGA. It holds the core in reset for a fixed number of cycles, lets it run,
// snoops the retire and store buses, and latches how the test ended:
// a tohost store (PASS/FAIL), a self-loop (HANG) or a cycle limit (TIMEOUT).
//
// Ports
//   clk, reset     : clock and asynchronous active-low harness reset
//   restart        : one-cycle pulse, re-runs the test from the reset hold
//   retire_valid   : an instruction retired this cycle
//   retire_pc      : PC of that instruction
//   mem_write      : data store strobe
//   mem_addr       : store byte address
//   mem_wdata      : store data
//   core_reset     : active-high reset to the core
//   running        : high while the core is running
//   done           : high once the test has ended
//   status         : run_state_t encoding of the current state
//   fail_code      : tohost value >> 1 after a FAIL, otherwise 0
//   cycle_count    : cycles spent running
//   retire_count   : instructions retired while running
// ---------------------------------------------------------------------------
module sim_run_controller
    import sim_ctrl_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter int              CNT_W        = 32,
    parameter int              RESET_CYCLES = 4,
    parameter int              MAX_CYCLES   = 1000,
    parameter logic [XLEN-1:0] TOHOST_ADDR  = 'h0000_1000,
    parameter int              LOOP_LIMIT   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             restart,
    input  logic             retire_valid,
    input  logic [XLEN-1:0]  retire_pc,
    input  logic             mem_write,
    input  logic [XLEN-1:0]  mem_addr,
    input  logic [XLEN-1:0]  mem_wdata,
    output logic             core_reset,
    output logic             running,
    output logic             done,
    output logic [2:0]       status,
    output logic [XLEN-2:0]  fail_code,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retire_count
);

    localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int LOOP_W = $clog2(LOOP_LIMIT + 1);

    run_state_t        state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [LOOP_W-1:0] loop_cnt;
    logic [LOOP_W-1:0] loop_next;
    logic [XLEN-1:0]   last_pc;
    logic              in_run;
    logic              tohost_hit;
    logic              loop_hit;
    logic              timeout_hit;

    assign in_run = (state == ST_RUN);

    // Termination conditions seen during the current run cycle. A store of
    // zero to tohost is treated as a no-op. The loop streak uses the value
    // the counter would take this cycle, so the LOOP_LIMIT-th identical
    // retire itself triggers HANG.
    always_comb begin
        loop_next = LOOP_W'(1);
        if (retire_pc == last_pc) begin
            loop_next = loop_cnt + LOOP_W'(1);
        end
    end

    assign tohost_hit  = mem_write && (mem_addr == TOHOST_ADDR) && (mem_wdata != '0);
    assign loop_hit    = retire_valid && (loop_next == LOOP_W'(LOOP_LIMIT));
    assign timeout_hit = (cycle_count == CNT_W'(MAX_CYCLES - 1));

    // Both counters are cleared by restart and only advance while running,
    // which also freezes them in the terminal states.
    sim_sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (restart),
        .inc   (in_run),
        .q     (cycle_count)
    );

    sim_sat_counter #(.W(CNT_W)) u_retire_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (restart),
        .inc   (in_run && retire_valid),
        .q     (retire_count)
    );

    // Main controller: reset hold, run with prioritised end-of-test checks
    // (tohost, then self-loop, then timeout), and sticky terminal states.
    // restart overrides everything and starts a fresh hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_HOLD;
            hold_cnt  <= '0;
            loop_cnt  <= '0;
            last_pc   <= '0;
            fail_code <= '0;
        end else if (restart) begin
            state     <= ST_HOLD;
            hold_cnt  <= '0;
            loop_cnt  <= '0;
            last_pc   <= '0;
            fail_code <= '0;
        end else begin
            case (state)
                ST_HOLD: begin
                    if (hold_cnt == HOLD_W'(RESET_CYCLES - 1)) begin
                        state    <= ST_RUN;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                ST_RUN: begin
                    if (retire_valid) begin
                        loop_cnt <= loop_next;
                        last_pc  <= retire_pc;
                    end
                    if (tohost_hit) begin
                        if (mem_wdata == XLEN'(TOHOST_PASS)) begin
                            state <= ST_PASS;
                        end else begin
                            state     <= ST_FAIL;
                            fail_code <= mem_wdata[XLEN-1:1];
                        end
                    end else if (loop_hit) begin
                        state <= ST_HANG;
                    end else if (timeout_hit) begin
                        state <= ST_TIMEOUT;
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

    // Outputs are pure decodes of the registered state: the core is held in
    // reset whenever it is not running, including after the test ends.
    assign status     = state;
    assign running    = in_run;
    assign core_reset = !in_run;
    assign done       = is_terminal(state);

endmodule

// File: tb/tb_sim_run_controller.sv
// ---------------------------------------------------------------------------
// tb_sim_run_controller
// Self-checking bench for sim_run_controller with default parameters.
// A behavioural model tracks the expected run outcome from the observable
// rules (hold length, run-cycle budget, retired-PC history, tohost stores)
// and is compared with the DUT on every falling clock edge. Directed
// sequences pin key values with literals, then a randomized soak follows.
// ---------------------------------------------------------------------------
module tb_sim_run_controller;

    localparam int          RESET_CYCLES = 4;
    localparam int          MAX_CYCLES   = 1000;
    localparam int          LOOP_LIMIT   = 8;
    localparam logic [31:0] TOHOST       = 32'h0000_1000;

    localparam int S_HOLD = 0, S_RUN = 1, S_PASS = 2, S_FAIL = 3, S_HANG = 4, S_TIMEOUT = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        restart = 1'b0;
    logic        retire_valid = 1'b0;
    logic [31:0] retire_pc = '0;
    logic        mem_write = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        core_reset, running, done;
    logic [2:0]  status;
    logic [30:0] fail_code;
    logic [31:0] cycle_count, retire_count;

    int n_checks = 0;
    int n_errors = 0;

    sim_run_controller #(
        .XLEN(32), .CNT_W(32), .RESET_CYCLES(RESET_CYCLES), .MAX_CYCLES(MAX_CYCLES),
        .TOHOST_ADDR(TOHOST), .LOOP_LIMIT(LOOP_LIMIT)
    ) dut (
        .clk(clk), .reset(reset), .restart(restart),
        .retire_valid(retire_valid), .retire_pc(retire_pc),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .core_reset(core_reset), .running(running), .done(done), .status(status),
        .fail_code(fail_code), .cycle_count(cycle_count), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    // Behavioural model: outcome code, completed hold cycles, run cycles and
    // retires as plain integers, and the full list of retired PCs this run.
    int          m_status = S_HOLD;
    int          m_hold = 0;
    longint      m_cycles = 0;
    longint      m_retires = 0;
    logic [30:0] m_fail = '0;
    logic [31:0] pcq[$];

    function automatic logic [31:0] sat32(input longint v);
        if (v > 64'sd4294967295) return 32'hFFFF_FFFF;
        return 32'(v);
    endfunction

    // Length of the run of identical PCs at the end of the retire history.
    function automatic int trailingSame();
        int n = 0;
        for (int i = pcq.size() - 1; i >= 0; i--) begin
            if (pcq[i] == pcq[pcq.size() - 1]) n++;
            else break;
        end
        return n;
    endfunction

    task automatic modelClear();
        m_status  = S_HOLD;
        m_hold    = 0;
        m_cycles  = 0;
        m_retires = 0;
        m_fail    = '0;
        pcq.delete();
    endtask

    // Model advance: one step per rising edge, reset applied asynchronously.
    always @(posedge clk or negedge reset) begin
        int streak;
        streak = 0;
        if (!reset || restart) begin
            modelClear();
        end else if (m_status == S_HOLD) begin
            m_hold++;
            if (m_hold >= RESET_CYCLES) m_status = S_RUN;
        end else if (m_status == S_RUN) begin
            m_cycles++;
            if (retire_valid) begin
                m_retires++;
                pcq.push_back(retire_pc);
                streak = trailingSame();
            end
            if (mem_write && mem_addr == TOHOST && mem_wdata != 0) begin
                if (mem_wdata == 1) begin
                    m_status = S_PASS;
                end else begin
                    m_status = S_FAIL;
                    m_fail   = mem_wdata[31:1];
                end
            end else if (streak >= LOOP_LIMIT) begin
                m_status = S_HANG;
            end else if (m_cycles == MAX_CYCLES) begin
                m_status = S_TIMEOUT;
            end
        end
    end

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        checkVal("status", 32'(status), 32'(m_status));
        checkVal("core_reset", 32'(core_reset), 32'(m_status != S_RUN));
        checkVal("running", 32'(running), 32'(m_status == S_RUN));
        checkVal("done", 32'(done), 32'(m_status >= S_PASS));
        checkVal("fail_code", 32'(fail_code), 32'(m_fail));
        checkVal("cycle_count", cycle_count, sat32(m_cycles));
        checkVal("retire_count", retire_count, sat32(m_retires));
    endtask

    // Compare process: outputs are stable mid-cycle.
    always @(negedge clk) checkOutput();

    task automatic setInputs(input bit rv, input logic [31:0] pc, input bit mw,
                             input logic [31:0] a, input logic [31:0] d);
        retire_valid = rv;
        retire_pc    = pc;
        mem_write    = mw;
        mem_addr     = a;
        mem_wdata    = d;
    endtask

    task automatic applyStimulus(input bit rv, input logic [31:0] pc, input bit mw,
                                 input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        #1;
        setInputs(rv, pc, mw, a, d);
    endtask

    // Returns at the falling edge where cycle_count equals k during a run.
    task automatic waitRunCycle(input int k);
        int budget;
        budget = 3000;
        setInputs(0, '0, 0, '0, '0);
        while (budget > 0) begin
            @(negedge clk);
            if (running && cycle_count == k) return;
            budget--;
        end
        n_checks++;
        n_errors++;
        $display("[TB] FAIL wait_run_cycle: got no run cycle, expected cycle %0d", k);
    endtask

    // Counts falling edges with the core held in reset until it runs.
    task automatic countHold(output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (running) return;
            if (core_reset) n++;
        end
    endtask

    task automatic pulseRestart();
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
    endtask

    initial begin
        int n;
        #1 reset = 1'b0;
        repeat (3) applyStimulus(0, '0, 0, '0, '0);
        checkVal("rst.core_reset", 32'(core_reset), 32'd1);
        checkVal("rst.status", 32'(status), 32'd0);
        checkVal("rst.running", 32'(running), 32'd0);
        checkVal("rst.done", 32'(done), 32'd0);
        checkVal("rst.cycle_count", cycle_count, 32'd0);

        // Hold length after harness reset release.
        @(posedge clk);
        #1 reset = 1'b1;
        countHold(n);
        checkVal("t1.hold_len", 32'(n), 32'd4);
        checkVal("t1.running", 32'(running), 32'd1);
        checkVal("t1.cycle0", cycle_count, 32'd0);
        checkVal("t1.model_cycle0", 32'(m_cycles), 32'd0);

        // Zero store ignored, then PASS at run cycle 20.
        waitRunCycle(10);
        #1 setInputs(0, '0, 1, TOHOST, 32'd0);
        applyStimulus(0, '0, 0, '0, '0);
        checkVal("t2.zero_store_ignored", 32'(status), 32'(S_RUN));
        waitRunCycle(20);
        #1 setInputs(0, '0, 1, TOHOST, 32'd1);
        applyStimulus(0, '0, 0, '0, '0);
        checkVal("t2.pass_status", 32'(status), 32'(S_PASS));
        checkVal("t2.pass_done", 32'(done), 32'd1);
        checkVal("t2.pass_core_reset", 32'(core_reset), 32'd1);
        checkVal("t2.pass_cycles", cycle_count, 32'd21);
        repeat (3) applyStimulus(0, '0, 1, TOHOST, 32'd7);
        setInputs(0, '0, 0, '0, '0);
        checkVal("t2.pass_sticky", 32'(status), 32'(S_PASS));
        checkVal("t2.cycles_frozen", cycle_count, 32'd21);

        // Restart from PASS.
        pulseRestart();
        checkVal("t3.restart_status", 32'(status), 32'(S_HOLD));
        checkVal("t3.restart_cycles", cycle_count, 32'd0);
        checkVal("t3.restart_core_reset", 32'(core_reset), 32'd1);
        countHold(n);
        checkVal("t3.hold_len", 32'(n), 32'd4);

        // FAIL on the same cycle as the 8th same-PC retire: tohost wins.
        #1 setInputs(1, 32'h40, 0, '0, '0);
        repeat (6) applyStimulus(1, 32'h40, 0, '0, '0);
        applyStimulus(1, 32'h40, 1, TOHOST, 32'h0000_000B);
        applyStimulus(0, '0, 0, '0, '0);
        checkVal("t3.fail_status", 32'(status), 32'(S_FAIL));
        checkVal("t3.fail_code", 32'(fail_code), 32'd5);
        checkVal("t3.model_fail_code", 32'(m_fail), 32'd5);
        checkVal("t3.retires", retire_count, 32'd8);

        // Loop detection with gaps; a different PC breaks the streak.
        pulseRestart();
        countHold(n);
        repeat (7) begin
            applyStimulus(1, 32'h40, 0, '0, '0);
            applyStimulus(0, '0, 0, '0, '0);
        end
        applyStimulus(1, 32'h44, 0, '0, '0);
        applyStimulus(0, '0, 0, '0, '0);
        repeat (7) begin
            applyStimulus(1, 32'h40, 0, '0, '0);
            applyStimulus(0, '0, 0, '0, '0);
        end
        checkVal("t4.no_hang", 32'(status), 32'(S_RUN));
        applyStimulus(1, 32'h40, 0, '0, '0);
        applyStimulus(0, '0, 0, '0, '0);
        checkVal("t4.hang", 32'(status), 32'(S_HANG));
        checkVal("t4.retires", retire_count, 32'd16);

        // Timeout after exactly MAX_CYCLES run cycles.
        pulseRestart();
        countHold(n);
        waitRunCycle(998);
        checkVal("t5.pre_timeout", 32'(status), 32'(S_RUN));
        waitRunCycle(999);
        applyStimulus(0, '0, 0, '0, '0);
        checkVal("t5.timeout", 32'(status), 32'(S_TIMEOUT));
        checkVal("t5.timeout_cycles", cycle_count, 32'd1000);

        // Tohost store in the final cycle beats the timeout.
        pulseRestart();
        countHold(n);
        waitRunCycle(999);
        #1 setInputs(0, '0, 1, TOHOST, 32'd1);
        applyStimulus(0, '0, 0, '0, '0);
        checkVal("t5.last_cycle_pass", 32'(status), 32'(S_PASS));
        checkVal("t5.last_cycle_count", cycle_count, 32'd1000);

        // Harness reset mid-run takes effect without a clock edge.
        pulseRestart();
        countHold(n);
        waitRunCycle(5);
        #1 setInputs(1, 32'h80, 0, '0, '0);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        checkVal("t6.async_status", 32'(status), 32'(S_HOLD));
        checkVal("t6.async_core_reset", 32'(core_reset), 32'd1);
        checkVal("t6.async_running", 32'(running), 32'd0);
        checkVal("t6.async_cycles", cycle_count, 32'd0);
        checkVal("t6.async_retires", retire_count, 32'd0);
        checkOutput();
        @(posedge clk);
        #1 reset = 1'b1;
        setInputs(0, '0, 0, '0, '0);
        countHold(n);
        checkVal("t6.hold_len", 32'(n), 32'd4);

        // Randomized soak against the model.
        for (int i = 0; i < 6000; i++) begin
            logic [31:0] pc, addr, wdata;
            bit          rv, mw;
            int          pick;
            rv    = ($urandom_range(0, 99) < 45);
            pc    = ($urandom_range(0, 99) < 80) ? 32'h40 : {$urandom_range(0, 7), 2'b00};
            mw    = ($urandom_range(0, 99) < 10);
            addr  = ($urandom_range(0, 19) == 0) ? TOHOST : {$urandom_range(0, 1023), 2'b00};
            pick  = $urandom_range(0, 2);
            wdata = (pick == 0) ? 32'd0 : (pick == 1) ? 32'd1 : $urandom;
            applyStimulus(rv, pc, mw, addr, wdata);
            restart = ($urandom_range(0, 99) < (done ? 15 : 1));
            reset   = ($urandom_range(0, 999) != 0);
        end
        applyStimulus(0, '0, 0, '0, '0);
        restart = 1'b0;
        reset   = 1'b1;
        repeat (3) applyStimulus(0, '0, 0, '0, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
